// File: rtl/ldpc_fetch_if.sv
// Handshake and data bus between ldpc_fetch, the bidin source, the LLR RAM and the decoder.
interface ldpc_fetch_if #(
    parameter int unsigned WID = 6,
    parameter int unsigned AW  = 14
);
    logic           bidin_rdy;
    logic           bidin_ena_out;
    logic [WID-1:0] bidin_dout;
    logic           ldpc_req;
    logic           ldpc_fin;
    logic           llr_we;
    logic [AW-1:0]  llr_addr;
    logic [WID-1:0] llr_wdata;
    logic           dec_start;
    logic           dec_done;
    logic [3:0]     cw_idx;
    logic           frame_done;
    logic           err;
    logic [15:0]    chk_sum;

    modport master (
        input  bidin_rdy, bidin_ena_out, bidin_dout, dec_done,
        output ldpc_req, ldpc_fin, llr_we, llr_addr, llr_wdata, dec_start,
               cw_idx, frame_done, err, chk_sum
    );

    modport slave (
        output bidin_rdy, bidin_ena_out, bidin_dout, dec_done,
        input  ldpc_req, ldpc_fin, llr_we, llr_addr, llr_wdata, dec_start,
               cw_idx, frame_done, err, chk_sum
    );
endinterface

// File: rtl/ldpc_fetch.sv
// Pulls CW_NUM codewords from bidin into the LLR RAM, starts the decoder and acknowledges each codeword.
// Define LDPC_FETCH_CHKSUM_EN to enable the per-codeword sample checksum on chk_sum (tied to 0 otherwise).
module ldpc_fetch #(
    parameter int unsigned WID       = 6,
    parameter int unsigned CW_LEN    = 9216,
    parameter int unsigned CW_NUM    = 15,
    parameter int unsigned AW        = 14,
    parameter int unsigned DRAIN_MAX = 15,
    parameter int unsigned GAP       = 2
) (
    input  logic         clk6,
    input  logic         rst,
    ldpc_fetch_if.master bus
);
    localparam int unsigned CW_W = $clog2(CW_LEN + 1);
    localparam int unsigned DR_W = $clog2(DRAIN_MAX + 1);
    localparam int unsigned GP_W = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_REQ, S_DRAIN, S_DEC, S_FIN, S_GAP
    } state_t;

    state_t          state_q;
    logic [CW_W-1:0] req_cnt_q;
    logic [CW_W-1:0] rx_cnt_q;
    logic [DR_W-1:0] drain_cnt_q;
    logic [GP_W-1:0] gap_cnt_q;
    logic [3:0]      cw_idx_q;
    logic            ldpc_req_q;
    logic            ldpc_fin_q;
    logic            llr_we_q;
    logic [AW-1:0]   llr_addr_q;
    logic [WID-1:0]  llr_wdata_q;
    logic            dec_start_q;
    logic            frame_done_q;
    logic            err_q;

    logic capture_c;
    logic rx_full_c;
    logic gap_done_c;
    logic last_cw_c;

    assign capture_c  = bus.bidin_ena_out && (state_q == S_REQ || state_q == S_DRAIN);
    assign rx_full_c  = (rx_cnt_q == CW_W'(CW_LEN));
    assign gap_done_c = (state_q == S_GAP) && (gap_cnt_q == GP_W'(GAP - 1));
    assign last_cw_c  = (cw_idx_q == 4'(CW_NUM - 1));

    always_ff @(posedge clk6 or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_cnt_q    <= '0;
            rx_cnt_q     <= '0;
            drain_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            cw_idx_q     <= '0;
            ldpc_req_q   <= 1'b0;
            ldpc_fin_q   <= 1'b0;
            llr_we_q     <= 1'b0;
            llr_addr_q   <= '0;
            llr_wdata_q  <= '0;
            dec_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ldpc_fin_q   <= 1'b0;
            dec_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            llr_we_q     <= 1'b0;

            // Sample capture; anything beyond CW_LEN is dropped and flagged.
            if (capture_c) begin
                if (!rx_full_c) begin
                    llr_we_q    <= 1'b1;
                    llr_addr_q  <= AW'(rx_cnt_q);
                    llr_wdata_q <= bus.bidin_dout;
                    rx_cnt_q    <= rx_cnt_q + CW_W'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.bidin_rdy) state_q <= S_ARM;
                end
                S_ARM: begin
                    cw_idx_q   <= '0;
                    req_cnt_q  <= '0;
                    rx_cnt_q   <= '0;
                    ldpc_req_q <= 1'b1;
                    state_q    <= S_REQ;
                end
                S_REQ: begin
                    req_cnt_q <= req_cnt_q + CW_W'(1);
                    if (req_cnt_q == CW_W'(CW_LEN - 1)) begin
                        ldpc_req_q  <= 1'b0;
                        drain_cnt_q <= '0;
                        state_q     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Late samples may still arrive; give up after DRAIN_MAX cycles.
                    if (rx_full_c) begin
                        dec_start_q <= 1'b1;
                        state_q     <= S_DEC;
                    end else if (drain_cnt_q == DR_W'(DRAIN_MAX - 1)) begin
                        err_q       <= 1'b1;
                        dec_start_q <= 1'b1;
                        state_q     <= S_DEC;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DR_W'(1);
                    end
                end
                S_DEC: begin
                    if (bus.dec_done) begin
                        ldpc_fin_q <= 1'b1;
                        state_q    <= S_FIN;
                    end
                end
                S_FIN: begin
                    rx_cnt_q  <= '0;
                    req_cnt_q <= '0;
                    gap_cnt_q <= '0;
                    state_q   <= S_GAP;
                end
                S_GAP: begin
                    gap_cnt_q <= gap_cnt_q + GP_W'(1);
                    if (gap_done_c) begin
                        if (last_cw_c) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end else begin
                            cw_idx_q   <= cw_idx_q + 4'd1;
                            ldpc_req_q <= 1'b1;
                            state_q    <= S_REQ;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef LDPC_FETCH_CHKSUM_EN
    logic        req_rise_c;
    logic [15:0] chk_q;

    assign req_rise_c = (state_q == S_ARM) || (gap_done_c && !last_cw_c);

    // Wrap-around sum of accepted samples, restarted with each request burst.
    always_ff @(posedge clk6 or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else if (req_rise_c) begin
            chk_q <= '0;
        end else if (capture_c && !rx_full_c) begin
            chk_q <= chk_q + 16'($signed(bus.bidin_dout));
        end
    end

    assign bus.chk_sum = chk_q;
`else
    assign bus.chk_sum = 16'h0000;
`endif

    assign bus.ldpc_req   = ldpc_req_q;
    assign bus.ldpc_fin   = ldpc_fin_q;
    assign bus.llr_we     = llr_we_q;
    assign bus.llr_addr   = llr_addr_q;
    assign bus.llr_wdata  = llr_wdata_q;
    assign bus.dec_start  = dec_start_q;
    assign bus.cw_idx     = cw_idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_ldpc_fetch.sv
// Self-checking bench for ldpc_fetch: bidin source, decoder and LLR RAM modelled behaviourally.
module tb_ldpc_fetch;
    localparam int unsigned WID       = 6;
    localparam int unsigned CW_LEN    = 16;
    localparam int unsigned CW_NUM    = 4;
    localparam int unsigned AW        = 5;
    localparam int unsigned DRAIN_MAX = 15;
    localparam int unsigned GAP       = 2;
    localparam int          BUDGET    = 3000;

    logic clk6 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk6 = ~clk6;

    ldpc_fetch_if #(.WID(WID), .AW(AW)) bus ();

    ldpc_fetch #(
        .WID(WID), .CW_LEN(CW_LEN), .CW_NUM(CW_NUM), .AW(AW),
        .DRAIN_MAX(DRAIN_MAX), .GAP(GAP)
    ) dut (
        .clk6(clk6),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Source / decoder model state
    logic p1;
    logic extra_pend;
    int   src_idx;
    int   dec_cnt;
    int   short_cw;
    int   ovf_cw;
    logic stray_en;
    logic fixed_mode;

    // Scoreboard state
    logic [WID-1:0] ram [0:(1<<AW)-1];
    logic [WID-1:0] cur_sent[$];
    int   burst_q[$];
    int   spacing_q[$];
    int   cur_writes, total_writes, addr_err, ds_n, fin_n, fd_n, overlap;
    int   req_len, last_req_cyc, fin_cyc, fd_cyc, fd_to_req;
    logic prev_req, fin_pending, fd_pending;
    int          cw_writes [CW_NUM];
    int          cw_bad    [CW_NUM];
    int          cw_idx_ds [CW_NUM];
    int          req_to_ds [CW_NUM];
    logic [15:0] cw_chk_got[CW_NUM];
    logic [15:0] cw_chk_exp[CW_NUM];
    logic        err_ds    [CW_NUM];

    task automatic clear_stats();
        ds_n = 0; fin_n = 0; fd_n = 0; overlap = 0; total_writes = 0; addr_err = 0;
        cur_writes = 0; src_idx = 0; req_len = 0; fd_to_req = -1;
        cur_sent.delete(); burst_q.delete(); spacing_q.delete();
        short_cw = -1; ovf_cw = -1; stray_en = 1'b0; fixed_mode = 1'b0;
        for (int i = 0; i < CW_NUM; i++) begin
            cw_writes[i] = -1; cw_bad[i] = -1; cw_idx_ds[i] = -1; req_to_ds[i] = -1;
            cw_chk_got[i] = 16'hxxxx; cw_chk_exp[i] = 16'h0; err_ds[i] = 1'bx;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.bidin_ena_out = 1'b0;
        bus.dec_done      = 1'b0;
        p1 = 1'b0; dec_cnt = 0; extra_pend = 1'b0;
        prev_req = 1'b0; fin_pending = 1'b0; fd_pending = 1'b0;
        repeat (2) @(posedge clk6);
        #1 rst = 1'b0;
        clear_stats();
    endtask

    // One clock: observe DUT outputs, update the scoreboard, then drive the next inputs.
    task automatic tick();
        int          n_acc;
        int          bad;
        logic [15:0] sum;
        logic        ena;
        @(posedge clk6);
        #1;
        cyc++;
        if (bus.ldpc_req && bus.ldpc_fin) overlap++;
        if (bus.ldpc_req && !prev_req) begin
            req_len = 0;
            if (fin_pending) begin spacing_q.push_back(cyc - fin_cyc); fin_pending = 1'b0; end
            if (fd_pending)  begin fd_to_req = cyc - fd_cyc; fd_pending = 1'b0; end
        end
        if (bus.ldpc_req) req_len++;
        if (!bus.ldpc_req && prev_req) begin
            burst_q.push_back(req_len);
            last_req_cyc = cyc - 1;
        end
        prev_req = bus.ldpc_req;

        if (bus.llr_we) begin
            total_writes++;
            if (int'(bus.llr_addr) != cur_writes) addr_err++;
            ram[bus.llr_addr] = bus.llr_wdata;
            cur_writes++;
        end

        if (bus.dec_start) begin
            n_acc = (cur_sent.size() < int'(CW_LEN)) ? cur_sent.size() : int'(CW_LEN);
            bad = 0;
            sum = 16'h0;
            for (int i = 0; i < n_acc; i++) begin
                if (ram[AW'(i)] !== cur_sent[i]) bad++;
                sum = sum + 16'($signed(cur_sent[i]));
            end
            if (ds_n < int'(CW_NUM)) begin
                cw_writes[ds_n]  = cur_writes;
                cw_bad[ds_n]     = bad;
                cw_idx_ds[ds_n]  = int'(bus.cw_idx);
                cw_chk_got[ds_n] = bus.chk_sum;
`ifdef LDPC_FETCH_CHKSUM_EN
                cw_chk_exp[ds_n] = sum;
`else
                cw_chk_exp[ds_n] = 16'h0;
`endif
                err_ds[ds_n]     = bus.err;
                req_to_ds[ds_n]  = cyc - last_req_cyc;
            end
            ds_n++;
            cur_sent.delete();
            cur_writes = 0;
            src_idx    = 0;
            extra_pend = 1'b0;
            dec_cnt    = int'($urandom_range(2, 12));
        end
        if (bus.ldpc_fin) begin fin_n++; fin_cyc = cyc; fin_pending = 1'b1; end
        if (bus.frame_done) begin fd_n++; fd_cyc = cyc; fd_pending = 1'b1; fin_pending = 1'b0; end

        bus.dec_done = 1'b0;
        if (dec_cnt > 0) begin
            dec_cnt--;
            if (dec_cnt == 0) bus.dec_done = 1'b1;
        end
        if (stray_en && bus.ldpc_req && req_len == 5) bus.dec_done = 1'b1;

        // bidin answers each request two cycles later
        ena = p1;
        p1  = bus.ldpc_req;
        if (ena) begin
            src_idx++;
            if (ds_n == short_cw && src_idx > int'(CW_LEN) - 3) ena = 1'b0;
            if (ds_n == ovf_cw && src_idx == int'(CW_LEN)) extra_pend = 1'b1;
        end else if (extra_pend) begin
            ena = 1'b1;
            extra_pend = 1'b0;
        end
        bus.bidin_ena_out = ena;
        if (fixed_mode && ds_n == 0)      bus.bidin_dout = 6'h3F;
        else if (fixed_mode && ds_n == 1) bus.bidin_dout = 6'h01;
        else                              bus.bidin_dout = WID'($urandom_range(0, (1 << WID) - 1));
        if (ena) cur_sent.push_back(bus.bidin_dout);
    endtask

    task automatic run_frame(output logic ok);
        int start_fd;
        start_fd = fd_n;
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            tick();
            if (fd_n > start_fd) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bus.bidin_rdy     = 1'b1;
        bus.bidin_ena_out = 1'b0;
        bus.bidin_dout    = '0;
        bus.dec_done      = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk6);
        #1;
        n_checks++;
        if ({bus.ldpc_req, bus.ldpc_fin, bus.llr_we, bus.llr_addr, bus.llr_wdata, bus.dec_start,
             bus.cw_idx, bus.frame_done, bus.err, bus.chk_sum} !== '0)
            $display("FAIL reset_outputs: got ldpc_req=%b ldpc_fin=%b llr_we=%b cw_idx=%0d err=%b, required all 0",
                     bus.ldpc_req, bus.ldpc_fin, bus.llr_we, bus.cw_idx, bus.err);
        else n_pass++;
        bus.bidin_rdy = 1'b0;
        apply_reset();
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (burst_q.size() != 0 || prev_req !== 1'b0)
            $display("FAIL idle_without_rdy: got %0d request bursts, required 0", burst_q.size());
        else n_pass++;
    endtask

    task automatic test_nominal();
        logic ok;
        int   bad_len, bad_cw, bad_idx, bad_chk, bad_sp;
        clear_stats();
        stray_en = 1'b1;
        bus.bidin_rdy = 1'b1;
        run_frame(ok);
        bad_len = 0; bad_cw = 0; bad_idx = 0; bad_chk = 0; bad_sp = 0;
        foreach (burst_q[i]) if (burst_q[i] != int'(CW_LEN)) bad_len++;
        foreach (spacing_q[i]) if (spacing_q[i] != int'(GAP) + 1) bad_sp++;
        for (int i = 0; i < CW_NUM; i++) begin
            if (cw_writes[i] != int'(CW_LEN) || cw_bad[i] != 0) bad_cw++;
            if (cw_idx_ds[i] != i) bad_idx++;
            if (cw_chk_got[i] !== cw_chk_exp[i]) bad_chk++;
        end
        n_checks++; if (ok !== 1'b1) $display("FAIL nominal_timeout: frame_done not seen in %0d cycles", BUDGET); else n_pass++;
        n_checks++; if (burst_q.size() != int'(CW_NUM)) $display("FAIL nominal_bursts: got %0d required %0d", burst_q.size(), CW_NUM); else n_pass++;
        n_checks++; if (bad_len != 0) $display("FAIL nominal_burst_len: %0d bursts not %0d cycles long", bad_len, CW_LEN); else n_pass++;
        n_checks++; if (fin_n != int'(CW_NUM)) $display("FAIL nominal_fin: got %0d required %0d", fin_n, CW_NUM); else n_pass++;
        n_checks++; if (ds_n != int'(CW_NUM)) $display("FAIL nominal_dec_start: got %0d required %0d", ds_n, CW_NUM); else n_pass++;
        n_checks++; if (fd_n != 1) $display("FAIL nominal_frame_done: got %0d required 1", fd_n); else n_pass++;
        n_checks++; if (bus.err !== 1'b0) $display("FAIL nominal_err: got %b required 0", bus.err); else n_pass++;
        n_checks++; if (bad_cw != 0 || addr_err != 0) $display("FAIL nominal_ram: %0d bad codewords, %0d address errors, required 0", bad_cw, addr_err); else n_pass++;
        n_checks++; if (bad_idx != 0) $display("FAIL nominal_cw_idx: %0d wrong indices, required 0", bad_idx); else n_pass++;
        n_checks++; if (bad_chk != 0) $display("FAIL nominal_chk_sum: %0d wrong sums (cw0 got %h required %h)", bad_chk, cw_chk_got[0], cw_chk_exp[0]); else n_pass++;
        n_checks++; if (overlap != 0) $display("FAIL nominal_req_fin_overlap: got %0d cycles required 0", overlap); else n_pass++;
        n_checks++; if (spacing_q.size() != int'(CW_NUM) - 1 || bad_sp != 0) $display("FAIL nominal_gap: %0d spacings, %0d not %0d", spacing_q.size(), bad_sp, GAP + 1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic ok;
        int   bad_sp, req_seen;
        clear_stats();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (prev_req) begin ok = 1'b1; break; end
        end
        bus.bidin_rdy = 1'b0;
        n_checks++; if (fd_to_req != 2) $display("FAIL b2b_restart: frame_done to ldpc_req got %0d required 2", fd_to_req); else n_pass++;
        run_frame(ok);
        bad_sp = 0;
        foreach (spacing_q[i]) if (spacing_q[i] != int'(GAP) + 1) bad_sp++;
        n_checks++; if (ok !== 1'b1 || fin_n != int'(CW_NUM)) $display("FAIL b2b_frame: ok=%b fin=%0d required %0d", ok, fin_n, CW_NUM); else n_pass++;
        n_checks++; if (spacing_q.size() != int'(CW_NUM) - 1 || bad_sp != 0) $display("FAIL b2b_gap: %0d spacings, %0d not %0d", spacing_q.size(), bad_sp, GAP + 1); else n_pass++;
        req_seen = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (prev_req) req_seen++; end
        n_checks++; if (req_seen != 0) $display("FAIL b2b_stop: got %0d request cycles with rdy low, required 0", req_seen); else n_pass++;
    endtask

    task automatic test_shortfall();
        logic ok;
        apply_reset();
        short_cw = 2;
        bus.bidin_rdy = 1'b1;
        run_frame(ok);
        bus.bidin_rdy = 1'b0;
        n_checks++; if (ok !== 1'b1 || fin_n != int'(CW_NUM) || ds_n != int'(CW_NUM)) $display("FAIL short_frame: ok=%b fin=%0d dec_start=%0d required %0d", ok, fin_n, ds_n, CW_NUM); else n_pass++;
        n_checks++; if (err_ds[1] !== 1'b0 || err_ds[2] !== 1'b1 || bus.err !== 1'b1) $display("FAIL short_err: cw1=%b cw2=%b end=%b required 0 1 1", err_ds[1], err_ds[2], bus.err); else n_pass++;
        n_checks++; if (req_to_ds[2] != int'(DRAIN_MAX) + 1) $display("FAIL short_drain: got %0d required %0d", req_to_ds[2], DRAIN_MAX + 1); else n_pass++;
        n_checks++; if (cw_writes[2] != int'(CW_LEN) - 3 || cw_bad[2] != 0) $display("FAIL short_writes: got %0d writes, %0d bad, required %0d, 0", cw_writes[2], cw_bad[2], CW_LEN - 3); else n_pass++;
        n_checks++; if (cw_chk_got[2] !== cw_chk_exp[2]) $display("FAIL short_chk_sum: got %h required %h", cw_chk_got[2], cw_chk_exp[2]); else n_pass++;
    endtask

    task automatic test_overflow();
        logic ok;
        apply_reset();
        ovf_cw = 1;
        bus.bidin_rdy = 1'b1;
        run_frame(ok);
        bus.bidin_rdy = 1'b0;
        n_checks++; if (ok !== 1'b1 || fin_n != int'(CW_NUM)) $display("FAIL ovf_frame: ok=%b fin=%0d required %0d", ok, fin_n, CW_NUM); else n_pass++;
        n_checks++; if (total_writes != int'(CW_NUM * CW_LEN) || cw_writes[1] != int'(CW_LEN) || cw_bad[1] != 0) $display("FAIL ovf_writes: total %0d cw1 %0d bad %0d, required %0d %0d 0", total_writes, cw_writes[1], cw_bad[1], CW_NUM * CW_LEN, CW_LEN); else n_pass++;
        n_checks++; if (err_ds[0] !== 1'b0 || err_ds[1] !== 1'b1 || bus.err !== 1'b1) $display("FAIL ovf_err: cw0=%b cw1=%b end=%b required 0 1 1", err_ds[0], err_ds[1], bus.err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic ok;
        int   bad_cw;
        apply_reset();
        bus.bidin_rdy = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            tick();
            if (ds_n == 2 && prev_req && req_len == 5) begin ok = 1'b1; break; end
        end
        n_checks++; if (ok !== 1'b1) $display("FAIL mid_reach: codeword 2 request phase not reached in %0d cycles", BUDGET); else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.ldpc_req, bus.ldpc_fin, bus.llr_we, bus.llr_addr, bus.llr_wdata, bus.dec_start,
             bus.cw_idx, bus.frame_done, bus.err, bus.chk_sum} !== '0)
            $display("FAIL mid_reset_outputs: got ldpc_req=%b cw_idx=%0d llr_we=%b, required all 0", bus.ldpc_req, bus.cw_idx, bus.llr_we);
        else n_pass++;
        apply_reset();
        run_frame(ok);
        bus.bidin_rdy = 1'b0;
        bad_cw = 0;
        for (int i = 0; i < CW_NUM; i++) if (cw_writes[i] != int'(CW_LEN) || cw_bad[i] != 0) bad_cw++;
        n_checks++; if (ok !== 1'b1 || fin_n != int'(CW_NUM)) $display("FAIL mid_restart_fin: ok=%b fin=%0d required %0d", ok, fin_n, CW_NUM); else n_pass++;
        n_checks++; if (cw_idx_ds[0] != 0 || burst_q.size() == 0 || bad_cw != 0) $display("FAIL mid_restart_cw0: idx=%0d bursts=%0d bad=%0d required 0 >0 0", cw_idx_ds[0], burst_q.size(), bad_cw); else n_pass++;
        n_checks++; if (bus.err !== 1'b0) $display("FAIL mid_restart_err: got %b required 0", bus.err); else n_pass++;
    endtask

    task automatic test_checksum();
        logic        ok;
        logic [15:0] exp0, exp1;
        apply_reset();
        fixed_mode = 1'b1;
        bus.bidin_rdy = 1'b1;
        run_frame(ok);
        bus.bidin_rdy = 1'b0;
`ifdef LDPC_FETCH_CHKSUM_EN
        exp0 = 16'(-int'(CW_LEN));
        exp1 = 16'(CW_LEN);
`else
        exp0 = 16'h0;
        exp1 = 16'h0;
`endif
        n_checks++; if (ok !== 1'b1 || cw_bad[0] != 0 || cw_bad[1] != 0) $display("FAIL chk_frame: ok=%b bad0=%0d bad1=%0d", ok, cw_bad[0], cw_bad[1]); else n_pass++;
        n_checks++; if (cw_chk_got[0] !== exp0) $display("FAIL chk_minus_one: got %h required %h", cw_chk_got[0], exp0); else n_pass++;
        n_checks++; if (cw_chk_got[1] !== exp1) $display("FAIL chk_plus_one: got %h required %h", cw_chk_got[1], exp1); else n_pass++;
    endtask

    initial begin
        clear_stats();
        p1 = 1'b0; dec_cnt = 0; extra_pend = 1'b0;
        prev_req = 1'b0; fin_pending = 1'b0; fd_pending = 1'b0;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_shortfall();
        test_overflow();
        test_reset_mid();
        test_checksum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
